dmem_arbiter: RTL and testbench

// - Two-requester arbiter in front of the single-port data memory (async read, sync write).

---
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: round-robin grant, locked bursts bounded by MAX_LOCK.
// Optional perf counters are compiled in when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 4,
  parameter int CNT_W    = 16
) (
  input  logic          iClk,
  input  logic          iReset_n,
  input  logic          iReq0,
  input  logic          iReq1,
  input  logic          iWe0,
  input  logic          iWe1,
  input  logic [AW-1:0] iAddr0,
  input  logic [AW-1:0] iAddr1,
  input  logic [DW-1:0] iWdata0,
  input  logic [DW-1:0] iWdata1,
  input  logic          iLock0,
  input  logic          iLock1,
  output logic          oGnt0,
  output logic          oGnt1,
  output logic [DW-1:0] oRdata0,
  output logic [DW-1:0] oRdata1,
  output logic          oRvalid0,
  output logic          oRvalid1,
  output logic          oMemWe,
  output logic [AW-1:0] oMemAddr,
  output logic [DW-1:0] oMemWdata,
  input  logic [DW-1:0] iMemRdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] oGntCnt0,
  output logic [CNT_W-1:0] oGntCnt1,
  output logic [CNT_W-1:0] oStallCnt
`endif
);

  localparam int LCW = $clog2(MAX_LOCK + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]     state_q, state_d;
  logic           last_q, last_d;
  logic [LCW-1:0] cnt_q, cnt_d;
  logic [LCW-1:0] run;
  logic           gnt0, gnt1, cont, lock_g;
  logic [DW-1:0]  rdata0_q, rdata1_q;
  logic           rvalid0_q, rvalid1_q;

  // An owner that stops requesting falls back to normal arbitration in the same cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (iReset_n) begin
      if (state_q == OWN0 && iReq0) begin
        gnt0 = 1'b1;
      end else if (state_q == OWN1 && iReq1) begin
        gnt1 = 1'b1;
      end else if (iReq0 && iReq1) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = iReq0;
        gnt1 = iReq1;
      end
    end
  end

  always_comb begin
    cont    = (state_q == OWN0 && gnt0) || (state_q == OWN1 && gnt1);
    run     = cont ? cnt_q + LCW'(1) : LCW'(1);
    lock_g  = gnt0 ? iLock0 : iLock1;
    state_d = IDLE;
    cnt_d   = '0;
    last_d  = last_q;
    if (gnt0 || gnt1) begin
      last_d = gnt1;
      // Reaching MAX_LOCK releases the lock; last_d already favours the other port.
      if (lock_g && run < LCW'(MAX_LOCK)) begin
        state_d = gnt0 ? OWN0 : OWN1;
        cnt_d   = run;
      end
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= gnt0 & ~iWe0;
      rvalid1_q <= gnt1 & ~iWe1;
      if (gnt0 && !iWe0) rdata0_q <= iMemRdata;
      if (gnt1 && !iWe1) rdata1_q <= iMemRdata;
    end
  end

  always_comb begin
    oMemWe    = 1'b0;
    oMemAddr  = '0;
    oMemWdata = '0;
    if (gnt0) begin
      oMemWe    = iWe0;
      oMemAddr  = iAddr0;
      oMemWdata = iWdata0;
    end else if (gnt1) begin
      oMemWe    = iWe1;
      oMemAddr  = iAddr1;
      oMemWdata = iWdata1;
    end
  end

  assign oGnt0    = gnt0;
  assign oGnt1    = gnt1;
  assign oRdata0  = rdata0_q;
  assign oRdata1  = rdata1_q;
  assign oRvalid0 = rvalid0_q;
  assign oRvalid1 = rvalid1_q;

`ifdef DMEM_ARB_PERF_EN
  logic [CNT_W-1:0] gcnt0_q, gcnt1_q, stall_q;
  logic [1:0]       stall_inc;
  logic [CNT_W:0]   stall_sum;

  always_comb begin
    stall_inc = {1'b0, iReq0 & ~gnt0} + {1'b0, iReq1 & ~gnt1};
    stall_sum = {1'b0, stall_q} + (CNT_W + 1)'(stall_inc);
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      stall_q <= '0;
    end else begin
      if (gnt0 && gcnt0_q != '1) gcnt0_q <= gcnt0_q + CNT_W'(1);
      if (gnt1 && gcnt1_q != '1) gcnt1_q <= gcnt1_q + CNT_W'(1);
      stall_q <= stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
    end
  end

  assign oGntCnt0  = gcnt0_q;
  assign oGntCnt1  = gcnt1_q;
  assign oStallCnt = stall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_dmem_arbiter;
  localparam int MAX_LOCK = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0] gcnt0, gcnt1, stall_cnt;
`endif

  logic [31:0] dmem [16];
  logic [31:0] ref_mem [16];

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int m_owner, m_run, m_last;
  logic [31:0] last0, last1;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(MAX_LOCK), .CNT_W(16)) dut (
    .iClk(clk), .iReset_n(rst_n),
    .iReq0(req0), .iReq1(req1), .iWe0(we0), .iWe1(we1),
    .iAddr0(addr0), .iAddr1(addr1), .iWdata0(wdata0), .iWdata1(wdata1),
    .iLock0(lock0), .iLock1(lock1),
    .oGnt0(gnt0), .oGnt1(gnt1), .oRdata0(rdata0), .oRdata1(rdata1),
    .oRvalid0(rvalid0), .oRvalid1(rvalid1),
    .oMemWe(mem_we), .oMemAddr(mem_addr), .oMemWdata(mem_wdata), .iMemRdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .oGntCnt0(gcnt0), .oGntCnt1(gcnt1), .oStallCnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = dmem[mem_addr[5:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[5:2]] <= mem_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_run   = 0;
    m_last  = 1;
    q0.delete();
    q1.delete();
  endtask

  // Drive one cycle of requests, check grant and memory port against the model, then advance.
  task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic l0, input logic r1, input logic w1, input logic [31:0] a1,
                      input logic [31:0] d1, input logic l1, output int g);
    logic        ewe, elk;
    logic [31:0] ea, ed;
    exp_t        e;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
    #1;
    if (m_owner == 0 && r0) g = 0;
    else if (m_owner == 1 && r1) g = 1;
    else if (r0 && r1) g = 1 - m_last;
    else if (r0) g = 0;
    else if (r1) g = 1;
    else g = -1;
    ewe = 1'b0; ea = '0; ed = '0; elk = 1'b0;
    if (g == 0) begin ewe = w0; ea = a0; ed = d0; elk = l0; end
    if (g == 1) begin ewe = w1; ea = a1; ed = d1; elk = l1; end
    chk("gnt0", 32'(gnt0), 32'(g == 0));
    chk("gnt1", 32'(gnt1), 32'(g == 1));
    chk("mem_we", 32'(mem_we), 32'(ewe));
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    if (g >= 0) begin
      if (ewe) begin
        ref_mem[ea[5:2]] = ed;
      end else begin
        e.data = ref_mem[ea[5:2]];
        e.due  = cyc + 1;
        if (g == 0) q0.push_back(e); else q1.push_back(e);
      end
      m_run   = (m_owner == g) ? m_run + 1 : 1;
      m_last  = g;
      m_owner = (elk && m_run < MAX_LOCK) ? g : -1;
    end else begin
      m_owner = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    int g;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt0"}, 32'(gnt0), 0);
    chk({tag, "_gnt1"}, 32'(gnt1), 0);
    chk({tag, "_rvalid0"}, 32'(rvalid0), 0);
    chk({tag, "_rvalid1"}, 32'(rvalid1), 0);
    chk({tag, "_rdata0"}, rdata0, 0);
    chk({tag, "_rdata1"}, rdata1, 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic mon(input int p, input logic v, input logic [31:0] d);
    exp_t e;
    int   n;
    n = (p == 0) ? q0.size() : q1.size();
    if (v) begin
      if (n == 0) begin
        chk($sformatf("rvalid%0d_unexpected", p), 32'(v), 0);
      end else begin
        e = (p == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("rdata%0d", p), d, e.data);
        chk($sformatf("rvalid%0d_cycle", p), cyc, e.due);
      end
      if (p == 0) last0 = d; else last1 = d;
    end else begin
      if (n > 0) begin
        e = (p == 0) ? q0[0] : q1[0];
        if (e.due <= cyc) begin
          chk($sformatf("rvalid%0d_missing", p), 32'(v), 1);
          if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
      chk($sformatf("rdata%0d_hold", p), d, (p == 0) ? last0 : last1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last0 = '0;
      last1 = '0;
    end else begin
      mon(0, rvalid0, rdata0);
      mon(1, rvalid1, rdata1);
    end
  end

  initial begin
    int g;
    int pat[5];
    logic        pr[2], pw[2], pl[2];
    logic [31:0] pa[2], pd[2];

    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    for (int i = 0; i < 16; i++) begin
      dmem[i]    = 32'h0101_0101 * i + 32'h0A00_0000;
      ref_mem[i] = dmem[i];
    end
    dmem[1] = 32'h1111_1111; ref_mem[1] = 32'h1111_1111;
    dmem[2] = 32'h2222_2222; ref_mem[2] = 32'h2222_2222;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Round-robin reads with both ports requesting continuously.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 32'h4, 0, 0, 1, 0, 32'h8, 0, 0, g);
      chk("rr_order", g, i % 2);
    end
`ifdef DMEM_ARB_PERF_EN
    chk("perf_gnt0", 32'(gcnt0), 5);
    chk("perf_gnt1", 32'(gcnt1), 5);
    chk("perf_stall", 32'(stall_cnt), 10);
`endif
    idle(2);

    // Write from port 0, then read back through port 1.
    step(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, g);
    step(0, 0, 0, 0, 0, 1, 0, 32'h10, 0, 0, g);
    chk("wr_rd_rvalid1", 32'(rvalid1), 1);
    chk("wr_rd_rdata1", rdata1, 32'hDEAD_BEEF);
    idle(2);

    // Lock bound: port 0 locked and port 1 waiting.
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 32'h4, 0, 1, 1, 0, 32'h8, 0, 0, g);
      pat[i] = g;
    end
    for (int i = 0; i < 5; i++) chk($sformatf("lock_bound_%0d", i), pat[i], (i < 4) ? 0 : 1);
    idle(2);

    // Owner stops requesting: the waiting port wins in the same cycle.
    step(1, 0, 32'h4, 0, 1, 0, 0, 0, 0, 0, g);
    step(0, 0, 0, 0, 0, 1, 0, 32'h8, 0, 0, g);
    chk("owner_drop_gnt", g, 1);
    idle(2);

    // Asynchronous reset in the middle of a lock.
    step(1, 0, 32'h4, 0, 1, 1, 0, 32'h8, 0, 0, g);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 0, 32'h4, 0, 0, 1, 0, 32'h8, 0, 0, g);
    chk("post_reset_first", g, 0);
    idle(2);

    // Random traffic; each request is held until granted.
    for (int p = 0; p < 2; p++) begin
      pr[p] = 0; pw[p] = 0; pl[p] = 0; pa[p] = 0; pd[p] = 0;
    end
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pr[p] && $urandom_range(0, 9) < 6) begin
          pr[p] = 1;
          pw[p] = $urandom_range(0, 2) == 0;
          pl[p] = $urandom_range(0, 1) == 1;
          pa[p] = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
          pd[p] = $urandom;
        end
      end
      step(pr[0], pw[0], pa[0], pd[0], pl[0], pr[1], pw[1], pa[1], pd[1], pl[1], g);
      if (g >= 0) pr[g] = 0;
    end
    idle(3);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
